// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter that shares one Avalon-MM slave port among
//   NUM_MASTERS masters. The owner is picked combinationally in IDLE (zero
//   cycle grant latency) and frozen in BUSY while the slave stalls.
//
//   Handshake: a master's command is accepted by the slave on a rising clk
//   edge where it is the owner (grant bit high) and its m_waitrequest is 0;
//   m_waitrequest of the owner mirrors avl_waitrequest, all other masters see 1.
//
// Parameters
//   NUM_MASTERS  number of masters (2..8)
//   ADDR_W       address width (data is 32 bits, byteenable 4 bits)
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   m_read/m_write      per-master command requests (master i at bit i)
//   m_address           per-master address, master i at slice i*ADDR_W
//   m_writedata         per-master write data, master i at slice i*32
//   m_byteenable        per-master byte enables, master i at slice i*4
//   m_waitrequest       per-master stall
//   m_readdata          slave read data broadcast to all masters
//   avl_*               slave-side command / address / data / stall
//   grant               one-hot current owner, zero when idle
//   state_dbg           FSM state (0 = IDLE, 1 = BUSY) for observation
//
// Configuration
//   BUS_ARBITER_RR_PRIO0_EN  when defined, master 0 wins every IDLE
//                            arbitration in which it requests.
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS*32-1:0]     m_writedata,
    input  logic [NUM_MASTERS*4-1:0]      m_byteenable,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [31:0]                   m_readdata,
    output logic                          avl_read,
    output logic                          avl_write,
    output logic [ADDR_W-1:0]             avl_address,
    output logic [31:0]                   avl_writedata,
    output logic [3:0]                    avl_byteenable,
    input  logic [31:0]                   avl_readdata,
    input  logic                          avl_waitrequest,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic                          state_dbg
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] last_owner, last_owner_nx;
    logic [IDX_W-1:0] busy_owner, busy_owner_nx;
    logic [IDX_W-1:0] pick;
    logic             pick_found;
    logic [IDX_W-1:0] owner;
    logic             owner_valid;
    logic [NUM_MASTERS-1:0] req;
    int               idx;

    assign req        = m_read | m_write;
    assign m_readdata = avl_readdata;
    assign state_dbg  = state;

    // Round-robin search starting after the last owner that completed.
    always_comb begin
        pick       = last_owner;
        pick_found = 1'b0;
        idx        = 0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last_owner) + k) % NUM_MASTERS;
            if (!pick_found && req[IDX_W'(idx)]) begin
                pick       = IDX_W'(idx);
                pick_found = 1'b1;
            end
        end
`ifdef BUS_ARBITER_RR_PRIO0_EN
        // Instruction fetch master overrides the rotation whenever it asks.
        if (req[0]) begin
            pick       = '0;
            pick_found = 1'b1;
        end
`endif
    end

    // Owner selection, slave-side mux, and next-state logic.
    always_comb begin
        owner          = pick;
        owner_valid    = pick_found;
        grant          = '0;
        m_waitrequest  = '1;
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_address    = '0;
        avl_writedata  = '0;
        avl_byteenable = '0;
        state_nx       = state;
        last_owner_nx  = last_owner;
        busy_owner_nx  = busy_owner;

        if (state == BUSY) begin
            // Frozen owner; if it drops its request the transfer is abandoned.
            owner       = busy_owner;
            owner_valid = req[busy_owner];
        end
        // Keep the slave side quiet while reset is held, even with requests up.
        owner_valid = owner_valid & rst_n;

        if (owner_valid) begin
            grant[owner]         = 1'b1;
            m_waitrequest[owner] = avl_waitrequest;
            avl_write            = m_write[owner];
            // A simultaneous read and write forwards only the write.
            avl_read             = m_read[owner] & ~m_write[owner];
            avl_address          = m_address[owner*ADDR_W +: ADDR_W];
            avl_writedata        = m_writedata[owner*32 +: 32];
            avl_byteenable       = m_byteenable[owner*4 +: 4];
        end

        case (state)
            IDLE: begin
                if (owner_valid) begin
                    if (avl_waitrequest) begin
                        state_nx      = BUSY;
                        busy_owner_nx = owner;
                    end else begin
                        last_owner_nx = owner;
                    end
                end
            end
            BUSY: begin
                if (!owner_valid) begin
                    state_nx = IDLE;
                end else if (!avl_waitrequest) begin
                    state_nx      = IDLE;
                    last_owner_nx = owner;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= IDX_W'(NUM_MASTERS - 1);
            busy_owner <= '0;
        end else begin
            state      <= state_nx;
            last_owner <= last_owner_nx;
            busy_owner <= busy_owner_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Directed bench for bus_arbiter_rr with four masters and 32-bit addresses.
//   Inputs change 1 time unit after a rising edge; outputs are compared 1 time
//   unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

    localparam int N  = 4;
    localparam int AW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    m_read;
    logic [N-1:0]    m_write;
    logic [N*AW-1:0] m_address;
    logic [N*32-1:0] m_writedata;
    logic [N*4-1:0]  m_byteenable;
    logic [N-1:0]    m_waitrequest;
    logic [31:0]     m_readdata;
    logic            avl_read;
    logic            avl_write;
    logic [AW-1:0]   avl_address;
    logic [31:0]     avl_writedata;
    logic [3:0]      avl_byteenable;
    logic [31:0]     avl_readdata;
    logic            avl_waitrequest;
    logic [N-1:0]    grant;
    logic            state_dbg;

    int checks   = 0;
    int failures = 0;

    bus_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_address      (m_address),
        .m_writedata    (m_writedata),
        .m_byteenable   (m_byteenable),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .avl_read       (avl_read),
        .avl_write      (avl_write),
        .avl_address    (avl_address),
        .avl_writedata  (avl_writedata),
        .avl_byteenable (avl_byteenable),
        .avl_readdata   (avl_readdata),
        .avl_waitrequest(avl_waitrequest),
        .grant          (grant),
        .state_dbg      (state_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        m_read          = 4'b1111;
        m_write         = '0;
        m_writedata     = '0;
        m_byteenable    = {4'hF, 4'hF, 4'hF, 4'hF};
        avl_readdata    = 32'h1234_5678;
        avl_waitrequest = 1'b0;
        for (int i = 0; i < N; i++) m_address[i*AW +: AW] = 32'h1000 + i * 32'h10;

        // Reset state, with all masters requesting.
        tick();
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_avl_read", 32'(avl_read), 32'h0);
        chk("rst_avl_write", 32'(avl_write), 32'h0);
        chk("rst_waitreq", 32'(m_waitrequest), 32'hF);
        chk("rst_state", 32'(state_dbg), 32'h0);
        chk("readdata_pass", m_readdata, 32'h1234_5678);

        // Reset release, all four reading: 0001, 0010, 0100, 1000, 0001.
        tick();
        rst_n = 1'b1;
        #1;
        chk("rr0_grant", 32'(grant), 32'h1);
        chk("rr0_waitreq", 32'(m_waitrequest), 32'hE);
        chk("rr0_addr", avl_address, 32'h1000);
        chk("rr0_read", 32'(avl_read), 32'h1);
        tick();
        chk("rr1_grant", 32'(grant), 32'h2);
        chk("rr1_addr", avl_address, 32'h1010);
        tick();
        chk("rr2_grant", 32'(grant), 32'h4);
        chk("rr2_addr", avl_address, 32'h1020);
        tick();
        chk("rr3_grant", 32'(grant), 32'h8);
        chk("rr3_waitreq", 32'(m_waitrequest), 32'h7);
        tick();
        chk("rr4_grant", 32'(grant), 32'h1);
        // Withdraw before master 0 completes: last owner stays 3.
        m_read = '0;
        #1;
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_read", 32'(avl_read), 32'h0);
        chk("idle_addr", avl_address, 32'h0);
        chk("idle_be", 32'(avl_byteenable), 32'h0);
        chk("idle_waitreq", 32'(m_waitrequest), 32'hF);

        // Masters 1 and 3 with last owner 3: 1 first, then 3.
        tick();
        m_read = 4'b1010;
        #1;
        chk("m13_first", 32'(grant), 32'h2);
        tick();
        chk("m13_second", 32'(grant), 32'h8);
        tick();
        m_read = '0;

        // Master 2 writes 0xDEADBEEF to 0x100, be 0011, slave stalls 3 cycles.
        m_write[2]              = 1'b1;
        m_address[2*AW +: AW]   = 32'h100;
        m_writedata[2*32 +: 32] = 32'hDEAD_BEEF;
        m_byteenable[2*4 +: 4]  = 4'b0011;
        avl_waitrequest         = 1'b1;
        #1;
        chk("wr_c1_grant", 32'(grant), 32'h4);
        chk("wr_c1_write", 32'(avl_write), 32'h1);
        chk("wr_c1_addr", avl_address, 32'h100);
        chk("wr_c1_be", 32'(avl_byteenable), 32'h3);
        chk("wr_c1_data", avl_writedata, 32'hDEAD_BEEF);
        chk("wr_c1_waitreq", 32'(m_waitrequest), 32'hF);
        tick();
        m_read[1] = 1'b1;
        #1;
        chk("wr_c2_state", 32'(state_dbg), 32'h1);
        chk("wr_c2_grant", 32'(grant), 32'h4);
        chk("wr_c2_write", 32'(avl_write), 32'h1);
        chk("wr_c2_read", 32'(avl_read), 32'h0);
        chk("wr_c2_addr", avl_address, 32'h100);
        chk("wr_c2_waitreq", 32'(m_waitrequest), 32'hF);
        tick();
        chk("wr_c3_grant", 32'(grant), 32'h4);
        chk("wr_c3_be", 32'(avl_byteenable), 32'h3);
        tick();
        avl_waitrequest = 1'b0;
        #1;
        chk("wr_c4_grant", 32'(grant), 32'h4);
        chk("wr_c4_write", 32'(avl_write), 32'h1);
        chk("wr_c4_waitreq", 32'(m_waitrequest), 32'hB);
        tick();
        m_write[2] = 1'b0;
        #1;
        chk("m1_after_grant", 32'(grant), 32'h2);
        chk("m1_after_read", 32'(avl_read), 32'h1);
        chk("m1_after_write", 32'(avl_write), 32'h0);
        chk("m1_after_addr", avl_address, 32'h1010);
        chk("m1_after_data", avl_writedata, 32'h0);
        tick();
        m_read = '0;

        // Read and write together on master 3: only the write goes out.
        m_read[3]  = 1'b1;
        m_write[3] = 1'b1;
        #1;
        chk("rw_grant", 32'(grant), 32'h8);
        chk("rw_write", 32'(avl_write), 32'h1);
        chk("rw_read", 32'(avl_read), 32'h0);
        tick();
        m_read  = '0;
        m_write = '0;

        // Owner abandons in BUSY: back to IDLE, last owner (3) kept.
        m_read[0]       = 1'b1;
        avl_waitrequest = 1'b1;
        #1;
        chk("drop_c1_grant", 32'(grant), 32'h1);
        tick();
        m_read[0] = 1'b0;
        #1;
        chk("drop_c2_state", 32'(state_dbg), 32'h1);
        chk("drop_c2_read", 32'(avl_read), 32'h0);
        chk("drop_c2_grant", 32'(grant), 32'h0);
        tick();
        chk("drop_idle", 32'(state_dbg), 32'h0);
        m_read          = 4'b0011;
        avl_waitrequest = 1'b0;
        #1;
        chk("drop_no_update", 32'(grant), 32'h1);
        tick();
        m_read = '0;

        // Reset in BUSY cycle 2 of a master 1 read.
        m_read[1]       = 1'b1;
        avl_waitrequest = 1'b1;
        #1;
        chk("rb_c1_grant", 32'(grant), 32'h2);
        tick();
        chk("rb_c2_busy", 32'(state_dbg), 32'h1);
        chk("rb_c2_read", 32'(avl_read), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rb_abort_read", 32'(avl_read), 32'h0);
        chk("rb_abort_grant", 32'(grant), 32'h0);
        chk("rb_abort_waitreq", 32'(m_waitrequest), 32'hF);
        chk("rb_abort_state", 32'(state_dbg), 32'h0);
        tick();
        avl_waitrequest = 1'b0;
        rst_n           = 1'b1;
        #1;
        chk("rb_fresh_grant", 32'(grant), 32'h2);
        chk("rb_fresh_state", 32'(state_dbg), 32'h0);
        chk("rb_fresh_waitreq", 32'(m_waitrequest), 32'hD);
        tick();
        m_read = '0;

        // Masters 0 and 2 continuously, from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_read = 4'b0101;
        #1;
`ifdef BUS_ARBITER_RR_PRIO0_EN
        chk("alt0", 32'(grant), 32'h1);
        tick();
        chk("alt1", 32'(grant), 32'h1);
        tick();
        chk("alt2", 32'(grant), 32'h1);
        tick();
        chk("alt3", 32'(grant), 32'h1);
`else
        chk("alt0", 32'(grant), 32'h1);
        tick();
        chk("alt1", 32'(grant), 32'h4);
        tick();
        chk("alt2", 32'(grant), 32'h1);
        tick();
        chk("alt3", 32'(grant), 32'h4);
`endif
        tick();
        m_read = '0;
        #1;
        chk("final_idle", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
